// File: rtl/pdm_mic_stream.sv
// -----------------------------------------------------------------------------
// pdm_mic_stream
//
// PDM microphone front-end. Generates the PDM clock from clk_i, decimates the
// 1-bit PDM stream into signed PCM samples with a boxcar (ones-count) filter,
// queues the samples in a small first-word-fall-through FIFO and delivers them
// over a valid/ready stream. A sticky flag records any sample dropped because
// the FIFO was full.
//
// Optional feature macro: PDM_STEREO_EN
//   defined   : a right-channel accumulator samples on PDM clock falling
//               events and pushes samples tagged chan=1, interleaved with left.
//   undefined : only the left channel exists; chan_o is constant 0.
//
// Handshake: a sample transfers on every rising clk_i edge where
// valid_o && ready_i. valid_o never depends on ready_i; data_o/chan_o are
// stable while valid_o is high and not accepted. ready_i while the FIFO is
// empty has no effect.
//
// Ports:
//   clk_i        in   system clock, sole clock domain
//   rst_i        in   synchronous active-high reset
//   en_i         in   capture enable (FIFO and ovf_o are retained when low)
//   pdm_clk_o    out  PDM clock to the microphone(s)
//   pdm_lrsel_o  out  microphone L/R select, constant 0
//   pdm_data_i   in   PDM data from the microphone(s)
//   data_o       out  FIFO head sample (holds last value when empty)
//   chan_o       out  FIFO head channel, 0 = left, 1 = right
//   valid_o      out  FIFO not empty
//   ready_i      in   consumer accepts the head sample
//   ovf_o        out  sticky overflow flag
//   ovf_clr_i    in   clears ovf_o (a simultaneous drop keeps it set)
// -----------------------------------------------------------------------------
module pdm_mic_stream #(
  parameter int CLK_DIV    = 100,
  parameter int DECIM      = 64,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic              pdm_clk_o,
  output logic              pdm_lrsel_o,
  input  logic              pdm_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              chan_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o,
  input  logic              ovf_clr_i
);

  localparam int HALF   = CLK_DIV / 2;
  localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LOG2D  = $clog2(DECIM);
  localparam int CNT_W  = LOG2D;
  localparam int ONES_W = LOG2D + 1;
  localparam int SH     = DATA_W - LOG2D - 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DECIM - 1);
  localparam logic [ONES_W-1:0] ONES_FULL = ONES_W'(DECIM);
  localparam logic [DATA_W-1:0] DECIM_W   = DATA_W'(DECIM);
  localparam logic [DATA_W-1:0] PCM_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [AW:0]       FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  // Ones-count to PCM: 2*ones - DECIM, scaled to full range. The all-ones
  // case would land exactly on +2^(DATA_W-1), which does not fit, so it
  // saturates to the largest positive code.
  function automatic logic [DATA_W-1:0] to_pcm(input logic [ONES_W-1:0] ones);
    logic [DATA_W-1:0] t;
    if (ones == ONES_FULL) begin
      return PCM_MAX;
    end
    t = (DATA_W'(ones) << 1) - DECIM_W;
    return t << SH;
  endfunction

  // ---------------------------------------------------------------------------
  // PDM clock divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             pdm_clk_q, pdm_clk_d;
  logic             div_tc;
  logic             rise_ev;

  assign div_tc  = en_i && (div_q == DIV_TC);
  // The event is named after the pdm_clk_o edge that the toggle produces.
  assign rise_ev = div_tc && !pdm_clk_q;

  always_comb begin
    div_d     = div_q;
    pdm_clk_d = pdm_clk_q;
    if (!en_i) begin
      div_d     = '0;
      pdm_clk_d = 1'b0;
    end else if (div_tc) begin
      div_d     = '0;
      pdm_clk_d = ~pdm_clk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Left channel accumulator (rise events)
  // ---------------------------------------------------------------------------
  logic [ONES_W-1:0] ones_l_q, ones_l_d, ones_l_sum;
  logic [CNT_W-1:0]  cnt_l_q, cnt_l_d;
  logic              l_done;

  assign ones_l_sum = ones_l_q + ONES_W'(pdm_data_i);
  assign l_done     = rise_ev && (cnt_l_q == CNT_LAST);

  always_comb begin
    ones_l_d = ones_l_q;
    cnt_l_d  = cnt_l_q;
    if (!en_i || l_done) begin
      ones_l_d = '0;
      cnt_l_d  = '0;
    end else if (rise_ev) begin
      ones_l_d = ones_l_sum;
      cnt_l_d  = cnt_l_q + CNT_W'(1);
    end
  end

`ifdef PDM_STEREO_EN
  // ---------------------------------------------------------------------------
  // Right channel accumulator (fall events)
  // ---------------------------------------------------------------------------
  logic              fall_ev;
  logic [ONES_W-1:0] ones_r_q, ones_r_d, ones_r_sum;
  logic [CNT_W-1:0]  cnt_r_q, cnt_r_d;
  logic              r_done;

  assign fall_ev    = div_tc && pdm_clk_q;
  assign ones_r_sum = ones_r_q + ONES_W'(pdm_data_i);
  assign r_done     = fall_ev && (cnt_r_q == CNT_LAST);

  always_comb begin
    ones_r_d = ones_r_q;
    cnt_r_d  = cnt_r_q;
    if (!en_i || r_done) begin
      ones_r_d = '0;
      cnt_r_d  = '0;
    end else if (fall_ev) begin
      ones_r_d = ones_r_sum;
      cnt_r_d  = cnt_r_q + CNT_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Push stage: the finished sample is registered and written one cycle later.
  // Left and right completions are at least CLK_DIV/2 cycles apart, so a
  // single stage serves both channels.
  // ---------------------------------------------------------------------------
  logic              push_q, push_d;
  logic [DATA_W-1:0] push_data_q, push_data_d;

`ifdef PDM_STEREO_EN
  logic              push_chan_q, push_chan_d;

  always_comb begin
    push_d      = l_done || r_done;
    push_chan_d = r_done;
    push_data_d = r_done ? to_pcm(ones_r_sum) : to_pcm(ones_l_sum);
  end
`else
  always_comb begin
    push_d      = l_done;
    push_data_d = to_pcm(ones_l_sum);
  end
`endif

  // ---------------------------------------------------------------------------
  // Sample FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, push_ok, drop;

  assign full    = (count_q == FULL_CNT);
  assign pop     = valid_o && ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok = push_q && (!full || pop);
  assign drop    = push_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A drop outranks a clear in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

`ifdef PDM_STEREO_EN
  logic chan_mem_q [FIFO_DEPTH];
  logic hold_chan_q, hold_chan_d;

  always_comb begin
    hold_chan_d = hold_chan_q;
    if (pop) begin
      hold_chan_d = chan_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      chan_mem_q[wr_ptr_q] <= push_chan_q;
    end
  end
`endif

  // Storage array carries no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q       <= '0;
      pdm_clk_q   <= 1'b0;
      ones_l_q    <= '0;
      cnt_l_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      ovf_q       <= 1'b0;
`ifdef PDM_STEREO_EN
      ones_r_q    <= '0;
      cnt_r_q     <= '0;
      push_chan_q <= 1'b0;
      hold_chan_q <= 1'b0;
`endif
    end else begin
      div_q       <= div_d;
      pdm_clk_q   <= pdm_clk_d;
      ones_l_q    <= ones_l_d;
      cnt_l_q     <= cnt_l_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      ovf_q       <= ovf_d;
`ifdef PDM_STEREO_EN
      ones_r_q    <= ones_r_d;
      cnt_r_q     <= cnt_r_d;
      push_chan_q <= push_chan_d;
      hold_chan_q <= hold_chan_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pdm_clk_o   = pdm_clk_q;
  assign pdm_lrsel_o = 1'b0;
  assign valid_o     = (count_q != '0);
  assign ovf_o       = ovf_q;
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : hold_q;
`ifdef PDM_STEREO_EN
  assign chan_o      = valid_o ? chan_mem_q[rd_ptr_q] : hold_chan_q;
`else
  assign chan_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_mic_stream.sv
// -----------------------------------------------------------------------------
// tb_pdm_mic_stream
//
// Directed bench for pdm_mic_stream with CLK_DIV=4, DECIM=8, DATA_W=16,
// FIFO_DEPTH=4. Inputs change and outputs are sampled on the falling edge.
// Enabled cycle k is tracked in cyc; PDM data is driven from an 8-bit
// pattern, bit n%8 on rise event n (0-based), and fall_bit on fall events.
// -----------------------------------------------------------------------------
module tb_pdm_mic_stream;

  localparam int CLK_DIV    = 4;
  localparam int DECIM      = 8;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i      = 1'b1;
  logic              en_i       = 1'b0;
  logic              pdm_data_i = 1'b0;
  logic              ready_i    = 1'b1;
  logic              ovf_clr_i  = 1'b0;
  logic              pdm_clk_o;
  logic              pdm_lrsel_o;
  logic [DATA_W-1:0] data_o;
  logic              chan_o;
  logic              valid_o;
  logic              ovf_o;

  pdm_mic_stream #(
    .CLK_DIV    (CLK_DIV),
    .DECIM      (DECIM),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .pdm_clk_o   (pdm_clk_o),
    .pdm_lrsel_o (pdm_lrsel_o),
    .pdm_data_i  (pdm_data_i),
    .data_o      (data_o),
    .chan_o      (chan_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];

  int       cyc      = 0;
  logic [7:0] pat    = 8'h00;
  logic     fall_bit = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s (cyc %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_data();
    if (cyc % 4 == 1) begin
      pdm_data_i = pat[((cyc - 1) / 4) % 8];
    end else if (cyc % 4 == 3) begin
      pdm_data_i = fall_bit;
    end else begin
      pdm_data_i = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    drive_data();
  endtask

  // The current cycle becomes enabled cycle 0.
  task automatic start_en();
    en_i = 1'b1;
    cyc  = 0;
    drive_data();
  endtask

  // Pop the queued expectations at one sample per cycle, then expect empty.
  task automatic drain(input string tag);
    en_i    = 1'b0;
    ready_i = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, 32'(valid_o), 32'd1);
      check({tag, "_data"}, 32'(data_o), 32'(exp_q.pop_front()));
      tick();
    end
    check({tag, "_empty"}, 32'(valid_o), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0]        pat_a [6] = '{8'hFF, 8'h00, 8'h3F, 8'h55, 8'h01, 8'h7F};
  logic [DATA_W-1:0] exp_a [6] = '{16'h7FFF, 16'h8000, 16'h4000, 16'h0000, 16'hA000, 16'h6000};
  logic [7:0]        pat_d [6] = '{8'h01, 8'h7F, 8'hFF, 8'h3F, 8'h00, 8'h55};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
    check("rst_lrsel",   32'(pdm_lrsel_o), 32'd0);
    check("rst_valid",   32'(valid_o), 32'd0);
    check("rst_data",    32'(data_o), 32'd0);
    check("rst_chan",    32'(chan_o), 32'd0);
    check("rst_ovf",     32'(ovf_o), 32'd0);
    rst_i = 1'b0;
    tick();

`ifdef PDM_STEREO_EN
    // Left from rise events (all 1), right from fall events (all 0).
    pat      = 8'hFF;
    fall_bit = 1'b0;
    ready_i  = 1'b1;
    start_en();
    for (int k = 1; k <= 33; k++) begin
      tick();
      check("st_valid", 32'(valid_o), 32'((k == 31) || (k == 33)));
      check("st_lrsel", 32'(pdm_lrsel_o), 32'd0);
      if (k == 31) begin
        check("st_left_data", 32'(data_o), 32'h7FFF);
        check("st_left_chan", 32'(chan_o), 32'd0);
      end
      if (k == 33) begin
        check("st_right_data", 32'(data_o), 32'h8000);
        check("st_right_chan", 32'(chan_o), 32'd1);
      end
    end
`else
    // Phase A: six back-to-back samples, one per decimation pattern.
    pat     = pat_a[0];
    ready_i = 1'b1;
    start_en();
    for (int k = 1; k <= 191; k++) begin
      tick();
      if (k < 32) check("a_pdm_clk", 32'(pdm_clk_o), 32'((k >> 1) & 1));
      check("a_valid", 32'(valid_o), 32'(k % 32 == 31));
      if (k % 32 == 31) begin
        check("a_data", 32'(data_o), 32'(exp_a[k / 32]));
        check("a_chan", 32'(chan_o), 32'd0);
        if (k / 32 + 1 < 6) pat = pat_a[k / 32 + 1];
      end
    end

    // Phase B: disable mid-sample, then re-enable with a fresh sample.
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_idle_pdm_clk", 32'(pdm_clk_o), 32'd0);
    end
    pat = 8'hFF;
    start_en();
    for (int k = 1; k <= 20; k++) tick();
    en_i = 1'b0;
    pat  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_off_pdm_clk", 32'(pdm_clk_o), 32'd0);
      check("b_off_valid", 32'(valid_o), 32'd0);
    end
    start_en();
    for (int k = 1; k <= 31; k++) begin
      tick();
      check("b_valid", 32'(valid_o), 32'(k == 31));
      if (k < 6) check("b_pdm_clk", 32'(pdm_clk_o), 32'((k >> 1) & 1));
    end
    check("b_data", 32'(data_o), 32'h8000);

    // Phase C: consumer stalls for six samples; four fit, two are dropped.
    pat = pat_a[0];
    for (int k = 32; k <= 224; k++) begin
      tick();
      ready_i = 1'b0;
      if (k % 32 == 31 && (k - 31) / 32 < 6) pat = pat_a[(k - 31) / 32];
      if (k == 63 || k == 224) begin
        check("c_head_valid", 32'(valid_o), 32'd1);
        check("c_head_data", 32'(data_o), 32'h7FFF);
      end
      if (k == 190) check("c_ovf_before", 32'(ovf_o), 32'd0);
      if (k == 191) check("c_ovf_after", 32'(ovf_o), 32'd1);
    end
    exp_q = '{16'h7FFF, 16'h8000, 16'h4000, 16'h0000};
    tick();
    drain("c_drain");
    check("c_ovf_sticky", 32'(ovf_o), 32'd1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("c_ovf_clr", 32'(ovf_o), 32'd0);

    // Phase D: push into a full FIFO alongside a pop, then a drop that
    // coincides with ovf_clr_i.
    ready_i = 1'b0;
    pat     = pat_d[0];
    start_en();
    for (int k = 1; k <= 191; k++) begin
      tick();
      ready_i   = (k == 158);
      ovf_clr_i = (k == 190);
      if (k % 32 == 31 && k / 32 + 1 < 6) pat = pat_d[k / 32 + 1];
      if (k == 158) check("d_head_before", 32'(data_o), 32'hA000);
      if (k == 159) begin
        check("d_head_after", 32'(data_o), 32'h6000);
        check("d_no_ovf", 32'(ovf_o), 32'd0);
      end
      if (k == 190) check("d_ovf_before", 32'(ovf_o), 32'd0);
      if (k == 191) check("d_drop_wins", 32'(ovf_o), 32'd1);
    end
    ovf_clr_i = 1'b0;
    exp_q = '{16'h6000, 16'h7FFF, 16'h4000, 16'h8000};
    tick();
    drain("d_drain");

    // Phase E: reset mid-operation with a queued sample and ovf_o set.
    ready_i = 1'b0;
    pat     = 8'hFF;
    start_en();
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k == 40) begin
        check("e_valid", 32'(valid_o), 32'd1);
        check("e_data", 32'(data_o), 32'h7FFF);
        check("e_ovf_kept", 32'(ovf_o), 32'd1);
      end
    end
    check("e_pdm_clk_high", 32'(pdm_clk_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("e_rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
    check("e_rst_valid",   32'(valid_o), 32'd0);
    check("e_rst_data",    32'(data_o), 32'd0);
    check("e_rst_chan",    32'(chan_o), 32'd0);
    check("e_rst_ovf",     32'(ovf_o), 32'd0);
    check("e_rst_lrsel",   32'(pdm_lrsel_o), 32'd0);
    pat     = 8'h55;
    ready_i = 1'b1;
    start_en();
    for (int k = 1; k <= 31; k++) begin
      tick();
      check("e_post_valid", 32'(valid_o), 32'(k == 31));
    end
    check("e_post_data", 32'(data_o), 32'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pdm_mic_stream.md
# pdm_mic_stream

Parametrised PDM microphone front-end that replaces the fixed-rate mic path. Generates the PDM clock and decimates the 1-bit stream to signed PCM with a boxcar (ones-count) filter. Queues samples in an internal FIFO and delivers them over a valid/ready stream, with a sticky overflow flag. Sits between the board microphone pins and the audio datapath, all in the `clk_i` domain.

## Interface
- `CLK_DIV`, 100: `clk_i` cycles per PDM clock period; even, ≥4 (100 MHz → 1 MHz PDM).
- `DECIM`, 64: PDM bits per PCM sample; power of 2, ≥4, with `log2(DECIM)+1 ≤ DATA_W`.
- `DATA_W`, 16: PCM sample width, two's complement.
- `FIFO_DEPTH`, 8: sample FIFO entries; power of 2, ≥2.

Ports:
- `clk_i` in 1: system clock; sole clock domain.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: capture enable.
- `pdm_clk_o` out 1: PDM clock to microphone(s).
- `pdm_lrsel_o` out 1: microphone L/R select; constant 0.
- `pdm_data_i` in 1: PDM data from microphone(s).
- `data_o` out DATA_W: FIFO head sample.
- `chan_o` out 1: FIFO head channel, 0 = left, 1 = right.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer accepts head.
- `ovf_o` out 1: sticky overflow flag.
- `ovf_clr_i` in 1: clears `ovf_o`.

## Operation
- Reset: `pdm_clk_o`=0, `pdm_lrsel_o`=0, `valid_o`=0, `data_o`=0, `chan_o`=0, `ovf_o`=0. Divider, accumulators and bit counters are 0; FIFO is empty.
- Divider: half-period counter runs 0..CLK_DIV/2−1 while `en_i`=1. At the terminal count it wraps to 0 and toggles `pdm_clk_o`.
- Rise event: terminal count with `pdm_clk_o`=0. Fall event: terminal count with `pdm_clk_o`=1.
- Left channel: on each rise event, sample `pdm_data_i`, add it to the left ones-count and increment the left bit counter.
- On the DECIM-th bit:
  - compute `pcm = 2·ones − DECIM` (range −DECIM..+DECIM);
  - scale: `pcm << (DATA_W − log2(DECIM) − 1)`, saturating to 2^(DATA_W−1)−1 when ones = DECIM;
  - push {chan=0, sample} on the next cycle;
  - restart the ones-count and bit counter.
- Right channel exists only with `PDM_STEREO_EN`. It works identically on fall events and pushes with chan=1.
- `en_i`=0:
  - `pdm_clk_o` is forced 0 on the next cycle;
  - divider, accumulators and bit counters clear;
  - FIFO contents and `ovf_o` are retained, so popping continues.
- FIFO: first-word fall-through. `data_o`/`chan_o` show the head whenever `valid_o`=1 and hold their last value when empty.
- Pop: when `valid_o && ready_i`.
- Push while full: accepted only if a pop occurs in the same cycle; otherwise the sample is dropped and `ovf_o` sets.
- Order: samples leave in push order. Left and right pushes never coincide because rise and fall events are CLK_DIV/2 cycles apart.
- Overflow flag: `ovf_o` holds until `ovf_clr_i`. A drop in the same cycle as `ovf_clr_i` wins, so `ovf_o` stays 1.
- `ready_i` while empty: no effect.

## Timing
- Enabled cycle 0 is the first cycle with `en_i`=1 after reset or after disable.
- Rise event n (n≥1) occurs at enabled cycle n·CLK_DIV − CLK_DIV/2 − 1. Fall event n occurs at n·CLK_DIV − 1.
- Sample latency:
  - FIFO push happens 1 cycle after the DECIM-th event;
  - `valid_o` asserts 2 cycles after it if the FIFO was empty.
- Pop: head advances the cycle after the handshake.
- `valid_o` throughput: a full FIFO drains at one sample per cycle.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight sample is discarded.

## Configuration
- `PDM_STEREO_EN` defined:
  - right-channel accumulator is compiled in;
  - one PCM sample per channel is produced every DECIM·CLK_DIV cycles, interleaved L then R.
- Undefined:
  - fall events are ignored and no right-channel logic exists;
  - `chan_o` is constant 0 and only left samples are produced.

## Test plan
(Unless noted: CLK_DIV=4, DECIM=8, DATA_W=16, FIFO_DEPTH=4, `ready_i`=1.)
- `pdm_data_i`=1 constant, `en_i` rises → rise events at enabled cycles 1,5,…,29. `valid_o` asserts at cycle 31 with `data_o`=0x7FFF (saturated) and `chan_o`=0.
- `pdm_data_i`=0 constant → each left sample = 0x8000. Data 1 on 6 of every 8 rise events → 0x4000. Data 1 on 4 of 8 → 0x0000.
- `PDM_STEREO_EN` defined, data=1 on rise events and 0 on fall events:
  - left sample 0x7FFF pushed at cycle 30;
  - right sample 0x8000 with `chan_o`=1 pushed at cycle 32;
  - `valid_o` pulses at cycles 31 and 33.
- `ready_i`=0 for 6 samples (mono) → first 4 samples stored and 2 dropped, with `ovf_o`=1. Raising `ready_i` then drains exactly 4 samples in order. `ovf_clr_i` pulse → `ovf_o`=0.
- Push when full, simultaneous with a pop → push accepted, no overflow, FIFO count unchanged.
- `en_i` dropped at cycle 20 then re-raised → `pdm_clk_o`=0 while disabled and the partial sample is discarded. The next sample appears 31 cycles after re-enable. `rst_i` pulse mid-sample → all outputs return to reset values on the next edge.
